// File: rtl/vec_loop_ctrl.sv
// vec_loop_ctrl
//   Queues loop instructions and walks each one over a 2-D index space,
//   presenting one (row, col, op) beat per accepted handshake to a
//   downstream array. Row is the inner index. Beats can be gated by a
//   per-channel sync token. After the last beat the block waits for the
//   array to report drained before it loads the next instruction.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   inst_valid / inst_ready      instruction push handshake
//   inst_row_end, inst_col_end   last row / column index of the instruction
//   inst_op                      opcode carried on every beat
//   inst_sync, inst_sync_sel     gate every beat on a token from this channel
//   sync_avail / sync_pop        token present per channel / one-hot consume
//   abort                        synchronous flush of current and queued work
//   arr_valid / arr_ready        beat handshake towards the array
//   arr_row, arr_col, arr_op     beat payload
//   arr_last                     final beat of the current instruction
//   arr_done                     array drained (only looked at while draining)
//   busy                         running, draining, or work queued
module vec_loop_ctrl #(
  parameter int ROW_W      = 4,
  parameter int COL_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NSYNC      = 2,
  parameter int OPW        = 8,
  localparam int SELW      = (NSYNC > 1) ? $clog2(NSYNC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [ROW_W-1:0] inst_row_end,
  input  logic [COL_W-1:0] inst_col_end,
  input  logic [OPW-1:0]   inst_op,
  input  logic             inst_sync,
  input  logic [SELW-1:0]  inst_sync_sel,
  input  logic [NSYNC-1:0] sync_avail,
  output logic [NSYNC-1:0] sync_pop,
  input  logic             abort,
  output logic             arr_valid,
  input  logic             arr_ready,
  output logic [ROW_W-1:0] arr_row,
  output logic [COL_W-1:0] arr_col,
  output logic [OPW-1:0]   arr_op,
  output logic             arr_last,
  input  logic             arr_done,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row_end;
    logic [COL_W-1:0] col_end;
    logic [OPW-1:0]   op;
    logic             sync;
    logic [SELW-1:0]  sel;
  } entry_t;

  entry_t           fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  state_t           state_r, state_nxt_s;
  logic [ROW_W-1:0] row_r, row_end_r;
  logic [COL_W-1:0] col_r, col_end_r;
  logic [OPW-1:0]   op_r;
  logic             cur_sync_r;
  logic [SELW-1:0]  cur_sel_r;

  logic             full_s, empty_s, push_s, pop_s;
  logic             valid_s, beat_s, at_end_s;
  logic [NSYNC-1:0] sync_pop_s;
  entry_t           new_entry_s, head_s;

  assign full_s   = (count_r == CW'(FIFO_DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign push_s   = inst_valid & inst_ready;
  // The head is only taken while idle; abort wins over the load.
  assign pop_s    = (state_r == ST_IDLE) & ~empty_s & ~abort;
  assign head_s   = fifo_mem_r[rd_ptr_r];
  assign at_end_s = (row_r == row_end_r) & (col_r == col_end_r);
  assign beat_s   = valid_s & arr_ready;

  // Out-of-range channel selects fall back to channel 0 before queuing.
  always_comb begin
    new_entry_s.row_end = inst_row_end;
    new_entry_s.col_end = inst_col_end;
    new_entry_s.op      = inst_op;
    new_entry_s.sync    = inst_sync;
    if (32'(inst_sync_sel) < NSYNC) begin
      new_entry_s.sel = inst_sync_sel;
    end else begin
      new_entry_s.sel = {SELW{1'b0}};
    end
  end

  // Instruction queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= new_entry_s;
    end
  end

  // Queue pointers and occupancy; abort empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (abort) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next state and beat offer; the offer never looks at arr_ready.
  always_comb begin
    state_nxt_s = state_r;
    valid_s     = 1'b0;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      valid_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) state_nxt_s = ST_RUN;
          else          state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          valid_s = ~cur_sync_r | sync_avail[cur_sel_r];
          if (valid_s & arr_ready & at_end_s) state_nxt_s = ST_DRAIN;
          else                                state_nxt_s = ST_RUN;
        end
        ST_DRAIN: begin
          if (arr_done) state_nxt_s = ST_IDLE;
          else          state_nxt_s = ST_DRAIN;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // One token consumed per gated beat, on the instruction's channel.
  always_comb begin
    sync_pop_s = {NSYNC{1'b0}};
    if (beat_s & cur_sync_r) begin
      sync_pop_s[cur_sel_r] = 1'b1;
    end else begin
      sync_pop_s = {NSYNC{1'b0}};
    end
  end

  // Current instruction and loop indices; row is the inner index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r      <= {ROW_W{1'b0}};
      col_r      <= {COL_W{1'b0}};
      row_end_r  <= {ROW_W{1'b0}};
      col_end_r  <= {COL_W{1'b0}};
      op_r       <= {OPW{1'b0}};
      cur_sync_r <= 1'b0;
      cur_sel_r  <= {SELW{1'b0}};
    end else if (abort) begin
      row_r      <= {ROW_W{1'b0}};
      col_r      <= {COL_W{1'b0}};
      op_r       <= {OPW{1'b0}};
      cur_sync_r <= 1'b0;
    end else if (pop_s) begin
      row_r      <= {ROW_W{1'b0}};
      col_r      <= {COL_W{1'b0}};
      row_end_r  <= head_s.row_end;
      col_end_r  <= head_s.col_end;
      op_r       <= head_s.op;
      cur_sync_r <= head_s.sync;
      cur_sel_r  <= head_s.sel;
    end else if (beat_s) begin
      if (at_end_s) begin
        row_r <= {ROW_W{1'b0}};
        col_r <= {COL_W{1'b0}};
      end else if (row_r == row_end_r) begin
        row_r <= {ROW_W{1'b0}};
        col_r <= col_r + COL_W'(1);
      end else begin
        row_r <= row_r + ROW_W'(1);
      end
    end
  end

  assign inst_ready = ~full_s & ~abort;
  assign arr_valid  = valid_s;
  assign arr_last   = valid_s & at_end_s;
  assign sync_pop   = sync_pop_s;
  assign arr_row    = row_r;
  assign arr_col    = col_r;
  assign arr_op     = op_r;
  assign busy       = (state_r != ST_IDLE) | ~empty_s;

endmodule

// File: tb/tb_vec_loop_ctrl.sv
// Testbench for vec_loop_ctrl: directed scenarios followed by a randomized
// run checked against a flattened expected-beat queue.
module tb_vec_loop_ctrl;
  localparam int ROW_W = 4, COL_W = 4, FIFO_DEPTH = 4, NSYNC = 2, OPW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, inst_valid, inst_ready, inst_sync, abort;
  logic [3:0] inst_row_end, inst_col_end;
  logic [7:0] inst_op;
  logic       inst_sync_sel;
  logic [1:0] sync_avail, sync_pop;
  logic arr_valid, arr_ready, arr_last, arr_done, busy;
  logic [3:0] arr_row, arr_col;
  logic [7:0] arr_op;

  vec_loop_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .FIFO_DEPTH(FIFO_DEPTH),
                  .NSYNC(NSYNC), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_row_end(inst_row_end), .inst_col_end(inst_col_end), .inst_op(inst_op),
    .inst_sync(inst_sync), .inst_sync_sel(inst_sync_sel), .sync_avail(sync_avail),
    .sync_pop(sync_pop), .abort(abort), .arr_valid(arr_valid), .arr_ready(arr_ready),
    .arr_row(arr_row), .arr_col(arr_col), .arr_op(arr_op), .arr_last(arr_last),
    .arr_done(arr_done), .busy(busy));

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] op;
    logic       last;
    logic       sync;
    logic       sel;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int beats, pops, k;
  logic prev_hold, post_abort, aborted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_inst(input logic [3:0] re, input logic [3:0] ce, input logic [7:0] op,
                          input logic s, input logic sel);
    inst_row_end = re; inst_col_end = ce; inst_op = op; inst_sync = s; inst_sync_sel = sel;
  endtask

  // Expected beats of one instruction, row varying fastest.
  task automatic add_inst(input logic [3:0] re, input logic [3:0] ce, input logic [7:0] op,
                          input logic s, input logic sel);
    for (int c = 0; c <= int'(ce); c++) begin
      for (int r = 0; r <= int'(re); r++) begin
        beat_t b;
        b.row = 4'(r); b.col = 4'(c); b.op = op;
        b.last = (r == int'(re)) && (c == int'(ce));
        b.sync = s; b.sel = sel;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_abort();
    cyc(); inst_valid = 1'b0; abort = 1'b1; settle();
    chk("abort_valid", arr_valid, 0);
    chk("abort_ready", inst_ready, 0);
    cyc(); abort = 1'b0; settle();
    chk("abort_busy", busy, 0);
    exp_q.delete();
  endtask

  task automatic model_cycle();
    logic [1:0] exp_pop;
    if (abort) begin
      chk("rnd_abort_valid", arr_valid, 0);
      chk("rnd_abort_pop", sync_pop, 0);
      chk("rnd_abort_ready", inst_ready, 0);
      exp_q.delete();
      post_abort = 1'b1;
    end else begin
      if (post_abort) chk("rnd_post_abort_busy", busy, 0);
      post_abort = 1'b0;
      if (exp_q.size() > 0) chk("rnd_busy", busy, 1);
      if (arr_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_valid", arr_valid, 0);
        end else begin
          chk("rnd_row", arr_row, exp_q[0].row);
          chk("rnd_col", arr_col, exp_q[0].col);
          chk("rnd_op", arr_op, exp_q[0].op);
          chk("rnd_last", arr_last, exp_q[0].last);
          if (exp_q[0].sync) chk("rnd_sync_gate", sync_avail[exp_q[0].sel], 1);
        end
      end else begin
        chk("rnd_last_idle", arr_last, 0);
      end
      exp_pop = 2'b00;
      if (arr_valid && arr_ready && exp_q.size() > 0 && exp_q[0].sync) exp_pop[exp_q[0].sel] = 1'b1;
      chk("rnd_sync_pop", sync_pop, exp_pop);
      if (arr_valid && arr_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (inst_valid && inst_ready)
        add_inst(inst_row_end, inst_col_end, inst_op, inst_sync, inst_sync_sel);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst_valid = 1'b0; abort = 1'b0; arr_ready = 1'b0; arr_done = 1'b0;
    sync_avail = 2'b00; post_abort = 1'b0;
    set_inst(4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    cyc(); cyc(); settle();
    chk("rst_valid", arr_valid, 0);
    chk("rst_ready", inst_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rowcolop", {arr_row, arr_col, arr_op}, 0);
    cyc(); rst_n = 1'b1;

    // Basic 3x2 loop, ready always high.
    cyc(); inst_valid = 1'b1; set_inst(4'd2, 4'd1, 8'h5A, 1'b0, 1'b0); arr_ready = 1'b1; settle();
    chk("t1_ready", inst_ready, 1);
    chk("t1_c0_valid", arr_valid, 0);
    for (int t = 1; t <= 9; t++) begin
      cyc(); inst_valid = 1'b0; settle();
      if (t >= 2 && t <= 7) begin
        k = t - 2;
        chk("t1_valid", arr_valid, 1);
        chk("t1_row", arr_row, k % 3);
        chk("t1_col", arr_col, k / 3);
        chk("t1_last", arr_last, (k == 5) ? 1 : 0);
        chk("t1_op", arr_op, 8'h5A);
      end else begin
        chk("t1_valid_off", arr_valid, 0);
        chk("t1_last_off", arr_last, 0);
      end
      chk("t1_busy", busy, 1);
    end
    cyc(); arr_done = 1'b1; settle();
    chk("t1_drain_busy", busy, 1);
    cyc(); arr_done = 1'b0; settle();
    chk("t1_idle_busy", busy, 0);

    // Same loop with arr_ready toggling.
    arr_done = 1'b1;
    cyc(); inst_valid = 1'b1; arr_ready = 1'b0; settle();
    beats = 0; prev_hold = 1'b0;
    for (int t = 1; t < 30; t++) begin
      cyc(); inst_valid = 1'b0; arr_ready = t[0]; settle();
      if (prev_hold) chk("t2_hold_valid", arr_valid, 1);
      if (arr_valid) begin
        chk("t2_row", arr_row, beats % 3);
        chk("t2_col", arr_col, beats / 3);
        chk("t2_op", arr_op, 8'h5A);
        chk("t2_last", arr_last, (beats == 5) ? 1 : 0);
        if (arr_ready) beats++;
      end
      prev_hold = arr_valid & ~arr_ready;
    end
    chk("t2_beats", beats, 6);
    chk("t2_busy", busy, 0);

    // Sync-gated loop on channel 1.
    arr_ready = 1'b1; pops = 0;
    cyc(); inst_valid = 1'b1; set_inst(4'd2, 4'd1, 8'hC3, 1'b1, 1'b1); sync_avail = 2'b01; settle();
    for (int t = 1; t < 40; t++) begin
      cyc(); inst_valid = 1'b0; sync_avail = {(t % 3 == 0), 1'b1}; settle();
      chk("t3_pop0", sync_pop[0], 0);
      chk("t3_pop1", sync_pop[1], arr_valid & arr_ready);
      if (!sync_avail[1]) chk("t3_gated", arr_valid, 0);
      if (arr_valid) begin
        chk("t3_row", arr_row, pops % 3);
        chk("t3_col", arr_col, pops / 3);
      end
      if (sync_pop[1]) pops++;
    end
    chk("t3_pops", pops, 6);

    // Queue fill: arr_done held low, six consecutive pushes.
    arr_done = 1'b0; sync_avail = 2'b00;
    for (int t = 0; t < 6; t++) begin
      cyc(); inst_valid = 1'b1; set_inst(4'd3, 4'd3, 8'(t), 1'b0, 1'b0); settle();
      chk("t4_ready_fill", inst_ready, (t < 5) ? 1 : 0);
    end
    for (int t = 6; t < 26; t++) begin
      cyc(); settle();
      chk("t4_ready_full", inst_ready, 0);
    end
    cyc(); arr_done = 1'b1; settle();
    chk("t4_ready_drain", inst_ready, 0);
    cyc(); arr_done = 1'b0; settle();
    chk("t4_ready_popcycle", inst_ready, 0);
    cyc(); settle();
    chk("t4_ready_after_pop", inst_ready, 1);
    do_abort();

    // Abort on the third beat with two instructions queued.
    beats = 0; aborted = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cyc(); inst_valid = (t < 3); set_inst(4'd3, 4'd3, 8'hA0, 1'b0, 1'b0);
      abort = (beats == 2); settle();
      if (abort) begin
        chk("t5_abort_valid", arr_valid, 0);
        chk("t5_abort_pop", sync_pop, 0);
        chk("t5_abort_ready", inst_ready, 0);
        aborted = 1'b1;
        break;
      end else if (arr_valid && arr_ready) begin
        beats++;
      end
    end
    chk("t5_aborted", aborted, 1);
    cyc(); abort = 1'b0; inst_valid = 1'b0; settle();
    chk("t5_busy", busy, 0);
    chk("t5_rowcol", {arr_row, arr_col}, 0);
    for (int t = 0; t < 10; t++) begin
      cyc(); settle();
      chk("t5_no_beat", arr_valid, 0);
    end

    // Reset mid-run.
    beats = 0;
    for (int t = 0; t < 20 && beats < 4; t++) begin
      cyc(); inst_valid = (t < 2); set_inst(4'd3, 4'd3, 8'h77, 1'b0, 1'b0); settle();
      if (arr_valid && arr_ready) beats++;
    end
    chk("t6_beats_before", beats, 4);
    cyc(); inst_valid = 1'b0; rst_n = 1'b0; settle();
    for (int t = 0; t < 2; t++) begin
      chk("t6_rst_outs", {arr_valid, arr_last, sync_pop, busy, arr_row, arr_col, arr_op}, 0);
      chk("t6_rst_ready", inst_ready, 1);
      cyc(); settle();
    end
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cyc(); settle();
      chk("t6_no_beat", arr_valid, 0);
      chk("t6_idle", busy, 0);
    end
    arr_done = 1'b1;
    cyc(); inst_valid = 1'b1; set_inst(4'd0, 4'd0, 8'h33, 1'b0, 1'b0); settle();
    cyc(); inst_valid = 1'b0; settle();
    chk("t6_new_c1", arr_valid, 0);
    cyc(); settle();
    chk("t6_new_c2", {arr_valid, arr_last, arr_op}, {1'b1, 1'b1, 8'h33});
    cyc(); cyc(); settle();
    chk("t6_new_done", busy, 0);

    // Randomized traffic against the expected-beat queue.
    exp_q.delete(); post_abort = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      cyc();
      inst_valid = ($urandom_range(0, 2) == 0);
      set_inst(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom), 1'($urandom));
      abort = ($urandom_range(0, 79) == 0);
      arr_ready = ($urandom_range(0, 3) != 0);
      sync_avail = 2'($urandom);
      arr_done = ($urandom_range(0, 2) == 0);
      settle();
      model_cycle();
    end
    inst_valid = 1'b0; abort = 1'b0; arr_ready = 1'b1; sync_avail = 2'b11; arr_done = 1'b1;
    for (int t = 0; t < 300; t++) begin
      cyc(); settle();
      model_cycle();
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("rnd_drained_queue", exp_q.size(), 0);
    chk("rnd_drained_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vec_loop_ctrl.md
VEC_LOOP_CTRL -- requirements
Module: vec_loop_ctrl

Interface
REQ-001 SHALL have parameter ROW_W, default 4, meaning row pointer width.
REQ-002 SHALL have parameter COL_W, default 4, meaning column pointer width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning instruction queue entries (power of 2, >=2).
REQ-004 SHALL have parameter NSYNC, default 2, meaning sync channel count; SELW = max(1, clog2(NSYNC)).
REQ-005 SHALL have parameter OPW, default 8, meaning opcode width.
REQ-006 SHALL have these ports (name, direction, width, meaning):
 clk  in  1  clock
 rst_n  in  1  reset, asynchronous, active-low
 inst_valid  in  1  instruction offered
 inst_ready  out  1  queue can accept
 inst_row_end  in  ROW_W  last row index
 inst_col_end  in  COL_W  last column index
 inst_op  in  OPW  opcode
 inst_sync  in  1  every beat gated by a sync token
 inst_sync_sel  in  SELW  sync channel index
 sync_avail  in  NSYNC  token present per channel
 sync_pop  out  NSYNC  token consume, one-hot
 abort  in  1  synchronous flush
 arr_valid  out  1  beat offered to array
 arr_ready  in  1  array accepts beat
 arr_row  out  ROW_W  current row
 arr_col  out  COL_W  current column
 arr_op  out  OPW  current opcode
 arr_last  out  1  final beat of instruction
 arr_done  in  1  array drained
 busy  out  1  activity flag

Function
REQ-007 SHALL queue instructions in a FIFO_DEPTH-entry FIFO; push = inst_valid & inst_ready; inst_ready = ~full & ~abort.
REQ-008 SHALL implement FSM IDLE, RUN, DRAIN.
REQ-009 In IDLE with FIFO non-empty, SHALL pop the head into current-instruction registers and enter RUN next cycle. An instruction pushed into an empty idle block at cycle t gives its first arr_valid at t+2.
REQ-010 In RUN, arr_valid = ~cur_sync | sync_avail[cur_sel]; arr_valid SHALL NOT depend on arr_ready.
REQ-011 beat = arr_valid & arr_ready; arr_row/arr_col/arr_op SHALL hold stable while arr_valid & ~arr_ready.
REQ-012 On each beat, SHALL advance row-major-inner: row increments; at row==row_end, row wraps to 0 and col increments.
REQ-013 SHALL issue (row_end+1)*(col_end+1) beats; row_end=col_end=0 gives one beat.
REQ-014 sync_pop[cur_sel] SHALL pulse for exactly one cycle per beat when cur_sync=1; other bits 0; never in IDLE/DRAIN.
REQ-015 An inst_sync_sel >= NSYNC SHALL be treated as channel 0.
REQ-016 arr_last = arr_valid & (row==row_end) & (col==col_end).
REQ-017 A beat with arr_last SHALL clear row/col to 0 and enter DRAIN.
REQ-018 In DRAIN, SHALL stay until arr_done=1, then go to IDLE; arr_done outside DRAIN SHALL be ignored.
REQ-019 Back-to-back instructions SHALL incur one IDLE cycle between DRAIN exit and the next RUN.
REQ-020 busy = (state != IDLE) | ~empty.
REQ-021 abort SHALL have priority over all events. In the abort cycle: arr_valid=0, sync_pop=0, push blocked. Next cycle: IDLE, pointers 0, FIFO empty.
REQ-022 Push while full SHALL NOT occur, since inst_ready is low. Push and pop in the same cycle SHALL keep occupancy unchanged.

Reset
REQ-023 During rst_n low, SHALL hold: state IDLE, FIFO empty, row/col/op registers 0.
REQ-024 During rst_n low, SHALL output: arr_valid/arr_last/sync_pop/busy = 0, arr_row/arr_col/arr_op = 0, inst_ready = 1.
REQ-025 Reset asserted mid-RUN SHALL discard the current and queued instructions. After release, no beat SHALL issue until a new push.

Verification (ROW_W=4, COL_W=4, FIFO_DEPTH=4, NSYNC=2, OPW=8)
REQ-026 Push row_end=2, col_end=1, op=0x5A, no sync, arr_ready=1 at cycle 0 -> arr_valid cycles 2-7, (row,col) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); arr_last only at cycle 7; arr_op=0x5A; DRAIN until arr_done.
REQ-027 Same instruction, arr_ready toggling 1/0 -> each output held through ready-low cycles; exactly 6 beats; same sequence.
REQ-028 inst_sync=1, sel=1, sync_avail[1] high every third cycle, sync_avail[0]=1 -> exactly 6 sync_pop[1] pulses, each coincident with a beat; sync_pop[0] never asserts.
REQ-029 arr_done held 0; push 6 instructions on consecutive cycles from cycle 0 -> first 5 accepted (one loaded to RUN, 4 queued); 6th sees inst_ready=0 until a pop.
REQ-030 abort at the 3rd beat of row_end=3, col_end=3 with 2 queued -> arr_valid 0 that cycle; next cycle IDLE, busy=0; no further beats.
REQ-031 rst_n low for 2 cycles mid-RUN -> all outputs 0 and inst_ready=1 during reset; no beat after release until a new push.
